dmi_responder: RTL
==================

# dmi_responder

Core-clock-domain DMI register responder: the far end of the JTAG DMI path. Consumes the synchronized `reg_en`/`reg_wr_en`/`reg_wr_addr`/`reg_wr_data` strobes and returns `rd_data`. Implements the minimal debug-module register set (data0, dmcontrol, dmstatus, abstractcs, command). Executes abstract GPR access commands against the core through a req/ack handshake with timeout.

## Interface
- `ACK_TIMEOUT`, 255: cycles `gpr_req` may stay unacknowledged before abort (≥1, counter width `$clog2(ACK_TIMEOUT+1)`).
- `clk` in 1: core clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `reg_en` in 1: one-cycle DMI access strobe.
- `reg_wr_en` in 1: write qualifier (valid with `reg_en`).
- `reg_wr_addr` in 7: DMI register address.
- `reg_wr_data` in 32: write data.
- `rd_data` out 32: registered read data.
- `dbg_halt_req` out 1: level halt request (dmcontrol.haltreq).
- `dbg_resume_req` out 1: one-cycle resume pulse.
- `ndmreset` out 1: system reset request.
- `core_halted` in 1: core is in debug halt.
- `gpr_req` out 1: GPR access request, held until ack/abort.
- `gpr_we` out 1: 1 = write GPR.
- `gpr_addr` out 5: GPR index (regno[4:0]).
- `gpr_wdata` out 32: data0 contents.
- `gpr_ack` in 1: access complete (one cycle).
- `gpr_rdata` in 32: read result, valid with `gpr_ack`.

## Operation
- Access = `reg_en` high in a cycle; write if `reg_wr_en`, else read.
- 0x04 data0: RW. Write while busy ignored and sets cmderr=1 if cmderr==0.
- 0x10 dmcontrol: [31] haltreq RW, [30] resumereq W-only (reads 0), [1] ndmreset RW, [0] dmactive RW. Writing dmactive=0 clears data0, cmderr, haltreq, ndmreset, resumeack, aborts FSM to IDLE. While dmactive=0, writes other than to dmcontrol are ignored.
- resumereq=1 with haltreq=0 in the same write: `dbg_resume_req` pulses next cycle, resumeack cleared; resumeack sets on the first cycle `core_halted` is low after the pulse.
- 0x11 dmstatus (RO): [17:16] resumeack, [11:10] ~core_halted, [9:8] core_halted, [7] 1, [3:0] 2.
- 0x16 abstractcs: [28:24] 0, [12] busy, [10:8] cmderr (write-1-to-clear), [3:0] 1.
- 0x17 command (WO, reads 0). If cmderr!=0: ignored. If busy: cmderr=1. Else check in order: cmdtype[31:24]!=0, aarsize[22:20]!=2, or transfer=1 with regno[15:0] outside 0x1000–0x101F → cmderr=2; core_halted=0 → cmderr=4. Valid with transfer[17]=0 → no-op, no busy. Valid with transfer=1 → start FSM, write[16] selects `gpr_we`.
- Other addresses: reads 0, writes ignored.
- FSM IDLE→XFER on start; XFER: `gpr_req`=1, timeout counter runs. `gpr_ack` → if read, data0←`gpr_rdata`; →IDLE. Counter reaches ACK_TIMEOUT without ack → cmderr=3, →IDLE. busy = (state==XFER). `gpr_ack` in IDLE ignored.

## Timing
- Reset values: `rd_data`=0, all outputs 0, all registers 0, state IDLE.
- Read at cycle N → `rd_data` valid N+1, held until next read; shows pre-update values of cycle N.
- Write at N takes effect at N+1 (`dbg_halt_req`, `ndmreset`, `gpr_req` rise at N+1).
- `gpr_addr`/`gpr_we`/`gpr_wdata` stable while `gpr_req` high; `gpr_req` drops the cycle after ack or timeout.
- Ack in the same cycle counter hits ACK_TIMEOUT: ack wins, no error.
- Ack coinciding with dmactive=0 write: abort wins, data0 cleared.
- `rst` mid-XFER: `gpr_req` low next cycle, state IDLE.
- cmderr W1C and new error in the same cycle: new error wins.

## Structure
- Shared package `dmi_pkg`: register address constants, cmderr codes (NONE=0, BUSY=1, NOTSUP=2, EXCEPTION=3, HALTRESUME=4), FSM state encoding, regno range constants.
- One sub-module `dmi_abstract_fsm`: IDLE/XFER state, timeout counter, gpr handshake; top holds register file and decode.

## Test plan
- Halt core, write command 0x0022_1005 (read x5), `gpr_ack` after 3 cycles with rdata 0xDEADBEEF → busy high 3 cycles, read 0x04 returns 0xDEADBEEF, cmderr 0.
- Write data0=0x1234_5678, command 0x0023_100A → `gpr_we`=1, `gpr_addr`=10, `gpr_wdata`=0x12345678.
- Command with core_halted=0 → cmderr=4; write abstractcs 0x700 → cmderr 0; command with aarsize=3 → cmderr=2.
- Withhold `gpr_ack`, ACK_TIMEOUT=8 → `gpr_req` high 8 cycles, then cmderr=3, busy 0; late ack ignored.
- Command while busy → cmderr=1; data0 write while busy ignored.
- dmcontrol write 0x4000_0001 → one-cycle `dbg_resume_req`; drop `core_halted` → dmstatus[17:16]=3; write 0 mid-XFER → `gpr_req` drops next cycle.

Source files
------------

// File: rtl/dmi_pkg.sv
// Shared constants and types for the core-side DMI register responder.
// Covers register addresses, cmderr codes, the FSM encoding and GPR regno bounds.
package dmi_pkg;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPTION  = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_XFER = 1'b1
    } fsm_state_e;

    localparam logic [15:0] REGNO_GPR_FIRST = 16'h1000;
    localparam logic [15:0] REGNO_GPR_LAST  = 16'h101F;
    localparam logic [2:0]  AARSIZE_32      = 3'd2;

    function automatic logic cmd_notsup(
        input logic [7:0]  cmdtype,
        input logic [2:0]  aarsize,
        input logic        transfer,
        input logic [15:0] regno
    );
        logic bad_regno;
        bad_regno = transfer &&
                    ((regno < REGNO_GPR_FIRST) || (regno > REGNO_GPR_LAST));
        return (cmdtype != 8'h00) || (aarsize != AARSIZE_32) || bad_regno;
    endfunction

endpackage

// File: rtl/dmi_abstract_fsm.sv
// Abstract-command transfer engine: drives the GPR req/ack handshake
// and aborts the request after ACK_TIMEOUT unacknowledged cycles.
module dmi_abstract_fsm
    import dmi_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       start_we,
    input  logic [4:0] start_addr,
    input  logic       abort,
    input  logic       gpr_ack,
    output logic       busy,
    output logic       gpr_req,
    output logic       gpr_we,
    output logic [4:0] gpr_addr,
    output logic       rd_done,
    output logic       timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    fsm_state_e    state;
    logic [CW-1:0] cnt;
    logic          xfer;

    assign xfer    = (state == FSM_XFER);
    assign busy    = xfer;
    // An ack on the last allowed cycle still counts as success.
    assign timeout = xfer && !abort && !gpr_ack &&
                     (cnt == CW'(ACK_TIMEOUT - 1));
    assign rd_done = xfer && !abort && gpr_ack && !gpr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FSM_IDLE;
            cnt      <= '0;
            gpr_req  <= 1'b0;
            gpr_we   <= 1'b0;
            gpr_addr <= '0;
        end else begin
            unique case (state)
                FSM_IDLE: begin
                    if (start) begin
                        state    <= FSM_XFER;
                        cnt      <= '0;
                        gpr_req  <= 1'b1;
                        gpr_we   <= start_we;
                        gpr_addr <= start_addr;
                    end
                end
                FSM_XFER: begin
                    if (abort || gpr_ack || timeout) begin
                        state   <= FSM_IDLE;
                        gpr_req <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= FSM_IDLE;
                    gpr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmi_responder.sv
// Core-clock DMI register responder: minimal debug-module register set
// plus abstract GPR access commands handed to dmi_abstract_fsm.
module dmi_responder
    import dmi_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_en,
    input  logic        reg_wr_en,
    input  logic [6:0]  reg_wr_addr,
    input  logic [31:0] reg_wr_data,
    output logic [31:0] rd_data,
    output logic        dbg_halt_req,
    output logic        dbg_resume_req,
    output logic        ndmreset,
    input  logic        core_halted,
    output logic        gpr_req,
    output logic        gpr_we,
    output logic [4:0]  gpr_addr,
    output logic [31:0] gpr_wdata,
    input  logic        gpr_ack,
    input  logic [31:0] gpr_rdata
);

    logic [31:0] data0;
    logic [2:0]  cmderr;
    logic        dmactive;
    logic        resumeack;
    logic        resume_pend;
    logic        busy;
    logic        rd_done;
    logic        timeout;
    logic        rd_acc;
    logic        wr_acc;
    logic        wr_ctl;
    logic        wr_data0;
    logic        wr_acs;
    logic        wr_cmd;
    logic        abort;
    logic        start;
    cmderr_e     cmd_err;
    logic [31:0] rd_mux;

    assign rd_acc   = reg_en && !reg_wr_en;
    assign wr_acc   = reg_en && reg_wr_en;
    assign wr_ctl   = wr_acc && (reg_wr_addr == ADDR_DMCONTROL);
    assign wr_data0 = wr_acc && dmactive && (reg_wr_addr == ADDR_DATA0);
    assign wr_acs   = wr_acc && dmactive && (reg_wr_addr == ADDR_ABSTRACTCS);
    assign wr_cmd   = wr_acc && dmactive && (reg_wr_addr == ADDR_COMMAND);
    assign abort    = wr_ctl && !reg_wr_data[0];
    assign gpr_wdata = data0;

    // A pending cmderr silently swallows further commands.
    always_comb begin
        cmd_err = CMDERR_NONE;
        start   = 1'b0;
        if (wr_cmd && (cmderr == CMDERR_NONE)) begin
            priority case (1'b1)
                busy:
                    cmd_err = CMDERR_BUSY;
                cmd_notsup(reg_wr_data[31:24], reg_wr_data[22:20],
                           reg_wr_data[17], reg_wr_data[15:0]):
                    cmd_err = CMDERR_NOTSUP;
                !core_halted:
                    cmd_err = CMDERR_HALTRESUME;
                default:
                    start = reg_wr_data[17];
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (reg_wr_addr)
            ADDR_DATA0:      rd_mux = data0;
            ADDR_DMCONTROL:  rd_mux = {dbg_halt_req, 29'b0, ndmreset, dmactive};
            ADDR_DMSTATUS:   rd_mux = {14'b0, {2{resumeack}}, 4'b0,
                                       {2{~core_halted}}, {2{core_halted}},
                                       1'b1, 3'b0, 4'd2};
            ADDR_ABSTRACTCS: rd_mux = {19'b0, busy, 1'b0, cmderr, 8'h01};
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data        <= '0;
            data0          <= '0;
            cmderr         <= CMDERR_NONE;
            dmactive       <= 1'b0;
            dbg_halt_req   <= 1'b0;
            dbg_resume_req <= 1'b0;
            ndmreset       <= 1'b0;
            resumeack      <= 1'b0;
            resume_pend    <= 1'b0;
        end else begin
            dbg_resume_req <= 1'b0;
            if (rd_acc)
                rd_data <= rd_mux;
            if (resume_pend && !dbg_resume_req && !core_halted) begin
                resumeack   <= 1'b1;
                resume_pend <= 1'b0;
            end
            if (wr_data0) begin
                if (!busy)
                    data0 <= reg_wr_data;
                else if (cmderr == CMDERR_NONE)
                    cmderr <= CMDERR_BUSY;
            end
            if (wr_acs)
                cmderr <= cmderr & ~reg_wr_data[10:8];
            if (cmd_err != CMDERR_NONE)
                cmderr <= cmd_err;
            if (rd_done)
                data0 <= gpr_rdata;
            if (timeout)
                cmderr <= CMDERR_EXCEPTION;
            // Deactivation is last so it overrides a coinciding ack.
            if (wr_ctl) begin
                dbg_halt_req <= reg_wr_data[31];
                ndmreset     <= reg_wr_data[1];
                dmactive     <= reg_wr_data[0];
                if (!reg_wr_data[0]) begin
                    data0        <= '0;
                    cmderr       <= CMDERR_NONE;
                    dbg_halt_req <= 1'b0;
                    ndmreset     <= 1'b0;
                    resumeack    <= 1'b0;
                    resume_pend  <= 1'b0;
                end else if (reg_wr_data[30] && !reg_wr_data[31]) begin
                    dbg_resume_req <= 1'b1;
                    resumeack      <= 1'b0;
                    resume_pend    <= 1'b1;
                end
            end
        end
    end

    dmi_abstract_fsm #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_we  (reg_wr_data[16]),
        .start_addr(reg_wr_data[4:0]),
        .abort     (abort),
        .gpr_ack   (gpr_ack),
        .busy      (busy),
        .gpr_req   (gpr_req),
        .gpr_we    (gpr_we),
        .gpr_addr  (gpr_addr),
        .rd_done   (rd_done),
        .timeout   (timeout)
    );

endmodule
